uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Fixed-baud UART receiver, 8N1 format: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Samples the asynchronous serial line `rx` in the system clock domain using a per-bit cycle counter.
- Presents each correctly framed byte on `data_out` with a one-cycle `data_valid` strobe.
- Sits at the serial input boundary and feeds byte-wide consumers (command parser, FIFO).

Parameters:
- CLKS_PER_BIT, default 104: system clock cycles per bit. 1 MHz clock / 104 ≈ 9600 baud. Legal range ≥ 8.
- HALF_BIT, default (CLKS_PER_BIT-1)/2 = 51: counter value at which the start bit is re-checked (bit centre).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  8  last correctly received byte; held between frames.
- data_valid  output  1  one-cycle pulse when data_out is updated.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-frame):
  - data_out=0x00, data_valid=0, state=IDLE, counters=0, shift register=0.
  - Both synchronizer flops = 1, so line idle is assumed.
- Input synchronizer: rx passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- Counter: clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx counts 0..7.
- State machine:
  - IDLE: clk_cnt=0, bit_idx=0. rs==0 → START.
  - START: clk_cnt increments each cycle. At clk_cnt==HALF_BIT:
    - rs==0 → clear clk_cnt, go to DATA.
    - rs==1 → glitch; go to IDLE with no output change.
  - DATA: at clk_cnt==CLKS_PER_BIT-1:
    - Sample rs into shift[bit_idx] (LSB first) and clear clk_cnt.
    - bit_idx==7 → go to STOP; otherwise bit_idx++.
  - STOP: at clk_cnt==CLKS_PER_BIT-1:
    - rs==1 → data_out<=shift, data_valid<=1 for exactly that next cycle, go to IDLE.
    - rs==0 (framing error) → discard the byte (data_out and data_valid unchanged), go to WAIT_IDLE.
  - WAIT_IDLE: remain until rs==1, then go to IDLE. This prevents a break condition from being read as a stream of 0x00 frames.
- data_valid is high for exactly one clk cycle per good frame and is low in every other cycle.
- Timing: the data_valid rising edge occurs 9.5×CLKS_PER_BIT + 2..4 cycles after the rx falling edge, i.e. 990..994 cycles at default settings.
- Back-to-back frames: after the valid pulse the FSM is in IDLE, so a new start edge is accepted from the cycle after the stop-bit centre. No dead time beyond that.
- rx activity during DATA or STOP does not restart the frame; only centre samples matter.
- data_out is never modified except on a good stop bit.

Test Plan:
- Reset, then send 0x31 (start 0, bits 1,0,0,0,1,1,0,0, stop 1), each level held 104 cycles → exactly one data_valid pulse; data_out==0x31 (49) and remains 0x31 200 cycles after the stop bit.
- Send 0x55 immediately followed by 0xAA with no idle gap → two data_valid pulses about 1040 cycles apart; data_out 0x55 then 0xAA.
- Drive rx low for 20 cycles, then high → no data_valid; FSM back in IDLE. A following 0x7E frame is received correctly.
- Send 0xA5 with the stop bit held low, then hold rx low for 500 cycles, then release → no data_valid; data_out keeps its prior value (0x00 after reset). A following 0x3C frame is received correctly.
- Assert rst after the 4th data bit of a frame, release after 10 cycles, then send 0xF0 → data_out==0x00 during reset; the later frame yields data_out==0xF0 with a single pulse.
- Send 0x00 and 0xFF frames → data_out 0x00 and 0xFF respectively, one pulse each; pulse timing within 990..994 cycles of the start edge.

Source files
------------

// File: rtl/uart_rx.sv
// Fixed-baud 8N1 UART receiver: 2-flop input synchronizer, centre-sampled bits,
// one-cycle data_valid strobe per correctly framed byte.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid
);

    localparam int unsigned    CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(HALF_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rs;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Synchronizer resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rs) state <= START;
                end
                START: begin
                    if (clk_cnt == MID) begin
                        clk_cnt <= '0;
                        state   <= rs ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt         <= '0;
                        shift[bit_idx]  <= rs;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        if (rs) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            // A low stop bit may be a break; wait for the line to recover.
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and randomized frames checked against
// a last-good-byte / expected-pulse model of the serial protocol.
module tb_uart_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         wide = 0;
    logic       prev_dv = 1'b0;
    logic [7:0] model_out = 8'h00;
    logic [7:0] got_q[$];
    int         lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the byte presented and its delay from the start edge.
    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(data_out);
            lat_q.push_back(cyc - fall_cyc);
            if (prev_dv) wide++;
        end
        prev_dv = data_valid;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b, input bit good_stop, input string tag);
        got_q.delete();
        lat_q.delete();
        wide = 0;
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good_stop ? 1'b1 : 1'b0);
        if (good_stop) model_out = b;
        check({tag, "_pulses"}, got_q.size(), good_stop ? 1 : 0);
        check({tag, "_width"}, wide, 0);
        check({tag, "_dout"}, int'(data_out), int'(model_out));
        if (good_stop && got_q.size() == 1) begin
            check({tag, "_byte"}, int'(got_q[0]), int'(b));
            check({tag, "_lat"}, int'(lat_q[0] >= 990 && lat_q[0] <= 994), 1);
        end
    endtask

    task automatic glitch(input int len, input string tag);
        got_q.delete();
        rx = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        idle(80);
        check({tag, "_pulses"}, got_q.size(), 0);
        check({tag, "_dout"}, int'(data_out), int'(model_out));
    endtask

    initial begin
        logic [7:0] rb;
        int         r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", int'(data_out), 0);
        check("rst_dv", int'(data_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        frame(8'h31, 1'b1, "f31");
        got_q.delete();
        idle(200);
        check("hold31_pulses", got_q.size(), 0);
        check("hold31_dout", int'(data_out), 49);

        frame(8'h55, 1'b1, "f55");
        frame(8'hAA, 1'b1, "fAA");
        idle(10);

        glitch(20, "glitch20");
        frame(8'h7E, 1'b1, "f7E");
        idle(10);

        // Framing error, then a long break before the line recovers.
        frame(8'hA5, 1'b0, "fA5bad");
        got_q.delete();
        rx = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        idle(10);
        check("break_pulses", got_q.size(), 0);
        check("break_dout", int'(data_out), int'(model_out));
        frame(8'h3C, 1'b1, "f3C");
        idle(10);

        // Reset in the middle of a frame, after the fourth data bit.
        got_q.delete();
        rb = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        rst = 1'b1;
        rx  = 1'b1;
        model_out = 8'h00;
        @(negedge clk);
        check("midrst_dout", int'(data_out), 0);
        check("midrst_dv", int'(data_valid), 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        check("midrst_pulses", got_q.size(), 0);
        check("midrst_dout_after", int'(data_out), 0);
        frame(8'hF0, 1'b1, "fF0");
        idle(5);

        frame(8'h00, 1'b1, "f00");
        frame(8'hFF, 1'b1, "fFF");
        idle(5);

        for (int k = 0; k < 24; k++) begin
            r  = int'($urandom_range(0, 9));
            rb = 8'($urandom_range(0, 255));
            if (r == 0) glitch(int'($urandom_range(1, 40)), "rnd_glitch");
            frame(rb, r != 1, "rnd");
            if (r == 1) begin
                rx = 1'b0;
                repeat (int'($urandom_range(0, 300))) @(posedge clk);
                #1;
                idle(5 + int'($urandom_range(0, 20)));
            end else begin
                idle(int'($urandom_range(0, 20)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
